lap_stop_watch: RTL and testbench
=================================

// Module: lap_stop_watch
// PURPOSE
//  Parametrised stopwatch with a multi-entry lap memory, next generation of the board stopwatch.
//  Counts BCD time in N_DIG digits at TICK_HZ resolution and drives one 7-seg pattern per digit via FND.
//  Stores up to LAP_DEPTH lap times in a circular buffer; a second display shows one selected lap.
//  Sits between the debounced push-buttons and the FND digit pins of the board top level.
// PARAMETERS
//  CLK_HZ     100_000_000  input clock frequency
//  TICK_HZ    10           count rate; prescaler terminal LST_CLK = CLK_HZ/TICK_HZ-1
//  N_DIG      3            BCD digits per time value (1..8)
//  LAP_DEPTH  4            lap entries (power of 2, >=2); PW = clog2(LAP_DEPTH)
// PORTS
//  i_Clk      in   1          system clock, rising edge
//  i_Rst      in   1          asynchronous, active-low reset
//  i_fStart   in   1          start/pause button, active-low
//  i_fStop    in   1          stop/clear button, active-low
//  i_fLap     in   1          lap-capture button, active-low
//  i_fView    in   1          next-lap-view button, active-low
//  o_Run      out  7*N_DIG    running time, FND pattern, digit k at [7k+6:7k]
//  o_Lap      out  7*N_DIG    selected lap time, same packing
//  o_LapIdx   out  PW         index of lap on o_Lap (0 = oldest stored)
//  o_LapCnt   out  PW+1       number of valid laps, 0..LAP_DEPTH
//  o_State    out  2          00 IDLE, 01 RUN, 10 PAUSE
//  o_Ovf      out  1          sticky: running count wrapped past all-9s
// BEHAVIOUR
//  Reset (i_Rst=0, async): state IDLE, prescaler 0, all digits 0, lap memory 0, LapCnt 0, LapIdx 0,
//   Ovf 0, button history regs = 1; o_Run/o_Lap = FND(0) on every digit.
//  Buttons: per button, c_X <= i_X each clock; press event fX = !i_X && c_X (one cycle per fall).
//   Event acts on the same rising edge it is seen; registered outputs change on that edge.
//  Event priority in one cycle: Stop > Start > Lap > View; lower events that cycle are dropped.
//  FSM:
//   IDLE : counter and prescaler held at 0. Start -> RUN. Stop -> clear lap memory, LapCnt, LapIdx, Ovf.
//   RUN  : prescaler counts 0..LST_CLK and wraps; at LST_CLK digit0 increments; digit k increments when
//          all lower digits are 9 on a tick; 9 -> 0 carries. All digits 9 on a tick -> all 0, Ovf <= 1.
//          Start -> PAUSE. Stop -> IDLE, counter/prescaler cleared, laps kept.
//          Lap -> write current count (pre-increment value of that cycle) at wr_ptr; wr_ptr+1 mod DEPTH;
//          LapCnt saturates at LAP_DEPTH; when full oldest entry is overwritten.
//          After a lap write LapIdx points at the newest entry (LapCnt-1 in logical order).
//   PAUSE: prescaler and digits frozen. Start -> RUN (prescaler resumes from held value).
//          Stop -> IDLE, counter cleared, laps kept. Lap ignored.
//  View (any state, LapCnt>0): LapIdx <= (LapIdx+1 == LapCnt) ? 0 : LapIdx+1. LapCnt=0: ignored.
//  Lap addressing: logical idx i maps to physical (rd_base + i) mod DEPTH, rd_base = wr_ptr when full,
//   else 0. o_Lap shows FND of entry LapIdx; LapCnt=0 -> FND(0).
//  Latency: first tick after entering RUN from IDLE occurs CLK_HZ/TICK_HZ cycles later.
//  Reset mid-operation returns immediately to reset values regardless of state or pending events.
// TESTING (CLK_HZ=10, TICK_HZ=1 -> LST_CLK=9, N_DIG=2, LAP_DEPTH=4)
//  Start pulse, hold 30 cycles -> digits 0,3 (value 03); o_State=01; pause -> value frozen 20 cycles.
//  Run to 99 then one more tick -> value 00, o_Ovf=1; Stop then Stop in IDLE -> o_Ovf=0.
//  Laps at values 02,05,07,09,11 -> LapCnt=4, entries oldest->newest 05,07,09,11; View x1 -> LapIdx 0 -> 05.
//  Start and Stop asserted same cycle in RUN -> IDLE, counter 00; Lap+View same cycle -> lap written only.
//  Button held low 50 cycles -> exactly one event; Lap in PAUSE -> LapCnt unchanged.
//  Assert i_Rst low mid-RUN between clock edges -> outputs at reset values before next edge.

Source files
------------

// File: rtl/lap_stop_watch.sv
// -----------------------------------------------------------------------------
// lap_stop_watch
//   Stopwatch that counts BCD time in N_DIG digits at TICK_HZ resolution and
//   keeps up to LAP_DEPTH lap times in a circular buffer. One 7-segment
//   display shows the running time and a second one shows a selected lap.
//   Segment patterns are active-high {g,f,e,d,c,b,a}. Digit k occupies
//   bits [7k+6:7k].
//
// Ports
//   i_Clk     system clock, rising edge
//   i_Rst     asynchronous reset, active-low
//   i_fStart  start/pause button, active-low, debounced upstream
//   i_fStop   stop/clear button, active-low
//   i_fLap    lap-capture button, active-low
//   i_fView   next-lap-view button, active-low
//   o_Run     running time, one 7-seg pattern per digit
//   o_Lap     selected lap time, same packing as o_Run
//   o_LapIdx  logical index of the lap on o_Lap (0 = oldest stored)
//   o_LapCnt  number of valid laps, 0..LAP_DEPTH
//   o_State   00 IDLE, 01 RUN, 10 PAUSE
//   o_Ovf     sticky flag, set when the running count wraps past all nines
// -----------------------------------------------------------------------------
module lap_stop_watch #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 10,
    parameter int N_DIG     = 3,
    parameter int LAP_DEPTH = 4,
    localparam int PW       = $clog2(LAP_DEPTH)
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_fStart,
    input  logic                 i_fStop,
    input  logic                 i_fLap,
    input  logic                 i_fView,
    output logic [7*N_DIG-1:0]   o_Run,
    output logic [7*N_DIG-1:0]   o_Lap,
    output logic [PW-1:0]        o_LapIdx,
    output logic [PW:0]          o_LapCnt,
    output logic [1:0]           o_State,
    output logic                 o_Ovf
);

    localparam int LST_CLK = CLK_HZ / TICK_HZ - 1;
    localparam int CW      = (LST_CLK > 0) ? $clog2(LST_CLK + 1) : 1;
    localparam logic [CW-1:0] LST   = CW'(LST_CLK);
    localparam logic [PW:0]   DEPTH = (PW+1)'(LAP_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    state_t                r_State;
    state_t                w_StateNext;

    logic                  r_cStart, r_cStop, r_cLap, r_cView;
    logic [CW-1:0]         r_Pre;
    logic [4*N_DIG-1:0]    r_Dig;
    logic [4*N_DIG-1:0]    r_Mem [LAP_DEPTH];
    logic [PW-1:0]         r_WrPtr;
    logic [PW:0]           r_LapCnt;
    logic [PW-1:0]         r_LapIdx;
    logic                  r_Ovf;

    logic                  w_evStart, w_evStop, w_evLap, w_evView;
    logic                  w_clrCnt, w_clrLaps, w_run, w_lapWr, w_view;
    logic [4*N_DIG-1:0]    w_DigNext;
    logic                  w_carry;
    logic [PW-1:0]         w_rdBase, w_rdPtr;
    logic [4*N_DIG-1:0]    w_LapVal;

    // BCD digit to 7-segment pattern; non-decimal codes blank the digit.
    function automatic logic [6:0] f_Fnd(input logic [3:0] d);
        case (d)
            4'd0:    f_Fnd = 7'h3F;
            4'd1:    f_Fnd = 7'h06;
            4'd2:    f_Fnd = 7'h5B;
            4'd3:    f_Fnd = 7'h4F;
            4'd4:    f_Fnd = 7'h66;
            4'd5:    f_Fnd = 7'h6D;
            4'd6:    f_Fnd = 7'h7D;
            4'd7:    f_Fnd = 7'h07;
            4'd8:    f_Fnd = 7'h7F;
            4'd9:    f_Fnd = 7'h6F;
            default: f_Fnd = 7'h00;
        endcase
    endfunction

    // A press is a high-to-low transition seen against last cycle's level.
    // Only the highest-priority event of a cycle survives: Stop > Start > Lap > View.
    assign w_evStop  = !i_fStop  && r_cStop;
    assign w_evStart = !i_fStart && r_cStart && !w_evStop;
    assign w_evLap   = !i_fLap   && r_cLap   && !w_evStop && !(!i_fStart && r_cStart);
    assign w_evView  = !i_fView  && r_cView  && !w_evStop && !(!i_fStart && r_cStart)
                       && !(!i_fLap && r_cLap);

    // Stepping lap view only makes sense when something is stored.
    assign w_view = w_evView && (r_LapCnt != '0);

    // Button history registers.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_cStart <= 1'b1;
            r_cStop  <= 1'b1;
            r_cLap   <= 1'b1;
            r_cView  <= 1'b1;
        end else begin
            r_cStart <= i_fStart;
            r_cStop  <= i_fStop;
            r_cLap   <= i_fLap;
            r_cView  <= i_fView;
        end
    end

    // State register.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_State <= S_IDLE;
        end else begin
            r_State <= w_StateNext;
        end
    end

    // Next state and datapath controls. Counting is suppressed on the edge
    // that leaves RUN so pause freezes exactly the value on display.
    always_comb begin
        w_StateNext = r_State;
        w_clrCnt    = 1'b0;
        w_clrLaps   = 1'b0;
        w_run       = 1'b0;
        w_lapWr     = 1'b0;
        case (r_State)
            S_IDLE: begin
                w_clrCnt = 1'b1;
                if (w_evStop) begin
                    w_clrLaps = 1'b1;
                end else if (w_evStart) begin
                    w_StateNext = S_RUN;
                end
            end
            S_RUN: begin
                if (w_evStop) begin
                    w_StateNext = S_IDLE;
                    w_clrCnt    = 1'b1;
                end else if (w_evStart) begin
                    w_StateNext = S_PAUSE;
                end else begin
                    w_run   = 1'b1;
                    w_lapWr = w_evLap;
                end
            end
            S_PAUSE: begin
                if (w_evStop) begin
                    w_StateNext = S_IDLE;
                    w_clrCnt    = 1'b1;
                end else if (w_evStart) begin
                    w_StateNext = S_RUN;
                end
            end
            default: begin
                w_StateNext = S_IDLE;
                w_clrCnt    = 1'b1;
            end
        endcase
    end

    // Ripple BCD increment; w_carry left set means every digit was nine.
    always_comb begin
        w_DigNext = r_Dig;
        w_carry   = 1'b1;
        for (int k = 0; k < N_DIG; k++) begin
            if (w_carry) begin
                if (r_Dig[4*k +: 4] == 4'd9) begin
                    w_DigNext[4*k +: 4] = 4'd0;
                end else begin
                    w_DigNext[4*k +: 4] = r_Dig[4*k +: 4] + 4'd1;
                    w_carry             = 1'b0;
                end
            end
        end
    end

    // Prescaler, time digits, overflow flag and lap memory.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_Pre    <= '0;
            r_Dig    <= '0;
            r_Ovf    <= 1'b0;
            r_WrPtr  <= '0;
            r_LapCnt <= '0;
            r_LapIdx <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                r_Mem[i] <= '0;
            end
        end else begin
            if (w_clrCnt) begin
                r_Pre <= '0;
                r_Dig <= '0;
            end else if (w_run) begin
                if (r_Pre == LST) begin
                    r_Pre <= '0;
                    r_Dig <= w_DigNext;
                    if (w_carry) begin
                        r_Ovf <= 1'b1;
                    end
                end else begin
                    r_Pre <= r_Pre + CW'(1);
                end
            end

            // The write pointer doubles as the oldest entry once the buffer
            // is full, so it must be cleared together with the count.
            if (w_clrLaps) begin
                r_Ovf    <= 1'b0;
                r_WrPtr  <= '0;
                r_LapCnt <= '0;
                r_LapIdx <= '0;
                for (int i = 0; i < LAP_DEPTH; i++) begin
                    r_Mem[i] <= '0;
                end
            end else if (w_lapWr) begin
                r_Mem[r_WrPtr] <= r_Dig;
                r_WrPtr        <= r_WrPtr + PW'(1);
                if (r_LapCnt != DEPTH) begin
                    r_LapCnt <= r_LapCnt + (PW+1)'(1);
                    r_LapIdx <= r_LapCnt[PW-1:0];
                end else begin
                    r_LapIdx <= '1;
                end
            end else if (w_view) begin
                if (({1'b0, r_LapIdx} + (PW+1)'(1)) == r_LapCnt) begin
                    r_LapIdx <= '0;
                end else begin
                    r_LapIdx <= r_LapIdx + PW'(1);
                end
            end
        end
    end

    // Logical lap index to physical slot: oldest entry sits at the write
    // pointer once the buffer has wrapped, otherwise at slot 0.
    assign w_rdBase = (r_LapCnt == DEPTH) ? r_WrPtr : '0;
    assign w_rdPtr  = w_rdBase + r_LapIdx;
    assign w_LapVal = (r_LapCnt == '0) ? '0 : r_Mem[w_rdPtr];

    // Segment encoding for both displays.
    always_comb begin
        o_Run = '0;
        o_Lap = '0;
        for (int k = 0; k < N_DIG; k++) begin
            o_Run[7*k +: 7] = f_Fnd(r_Dig[4*k +: 4]);
            o_Lap[7*k +: 7] = f_Fnd(w_LapVal[4*k +: 4]);
        end
    end

    assign o_LapIdx = r_LapIdx;
    assign o_LapCnt = r_LapCnt;
    assign o_State  = r_State;
    assign o_Ovf    = r_Ovf;

endmodule

// File: tb/tb_lap_stop_watch.sv
// -----------------------------------------------------------------------------
// tb_lap_stop_watch
//   Directed bench for lap_stop_watch at CLK_HZ=10, TICK_HZ=1 (one tick per
//   ten clocks), two digits and four lap entries. Inputs change on the
//   falling clock edge and outputs are sampled there too, away from the
//   rising edge where the design acts.
// -----------------------------------------------------------------------------
module tb_lap_stop_watch;

    localparam int N_DIG = 2;
    localparam int PW    = 2;

    localparam logic [3:0] B_START = 4'b0001;
    localparam logic [3:0] B_STOP  = 4'b0010;
    localparam logic [3:0] B_LAP   = 4'b0100;
    localparam logic [3:0] B_VIEW  = 4'b1000;

    logic                clk;
    logic                rst_n;
    logic                fStart, fStop, fLap, fView;
    logic [7*N_DIG-1:0]  run;
    logic [7*N_DIG-1:0]  lap;
    logic [PW-1:0]       lapIdx;
    logic [PW:0]         lapCnt;
    logic [1:0]          state;
    logic                ovf;

    int nCompared   = 0;
    int nMismatched = 0;

    lap_stop_watch #(
        .CLK_HZ    (10),
        .TICK_HZ   (1),
        .N_DIG     (N_DIG),
        .LAP_DEPTH (4)
    ) dut (
        .i_Clk    (clk),
        .i_Rst    (rst_n),
        .i_fStart (fStart),
        .i_fStop  (fStop),
        .i_fLap   (fLap),
        .i_fView  (fView),
        .o_Run    (run),
        .o_Lap    (lap),
        .o_LapIdx (lapIdx),
        .o_LapCnt (lapCnt),
        .o_State  (state),
        .o_Ovf    (ovf)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not finish (got timeout, expected completion)");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference 7-segment table, active-high {g,f,e,d,c,b,a}.
    function automatic logic [6:0] segOf(input int d);
        case (d)
            0: segOf = 7'h3F;
            1: segOf = 7'h06;
            2: segOf = 7'h5B;
            3: segOf = 7'h4F;
            4: segOf = 7'h66;
            5: segOf = 7'h6D;
            6: segOf = 7'h7D;
            7: segOf = 7'h07;
            8: segOf = 7'h7F;
            9: segOf = 7'h6F;
            default: segOf = 7'h00;
        endcase
    endfunction

    // Two-digit decimal value to the packed display word.
    function automatic logic [13:0] fnd2(input int v);
        fnd2 = {segOf(v / 10), segOf(v % 10)};
    endfunction

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulls the selected buttons low across one rising edge, then releases
    // them for one more edge so back-to-back presses each form a fresh fall.
    task automatic applyStimulus(input logic [3:0] btn);
        fStart = !btn[0];
        fStop  = !btn[1];
        fLap   = !btn[2];
        fView  = !btn[3];
        @(negedge clk);
        fStart = 1'b1;
        fStop  = 1'b1;
        fLap   = 1'b1;
        fView  = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        fStart = 1'b1;
        fStop  = 1'b1;
        fLap   = 1'b1;
        fView  = 1'b1;
        waitCycles(3);
        checkOutput("rst_run",    32'(run),    32'(fnd2(0)));
        checkOutput("rst_lap",    32'(lap),    32'(fnd2(0)));
        checkOutput("rst_idx",    32'(lapIdx), 32'd0);
        checkOutput("rst_cnt",    32'(lapCnt), 32'd0);
        checkOutput("rst_state",  32'(state),  32'd0);
        checkOutput("rst_ovf",    32'(ovf),    32'd0);
        rst_n = 1'b1;
        waitCycles(2);

        // Start, then 30 clocks from the start edge give three ticks.
        applyStimulus(B_START);
        waitCycles(29);
        checkOutput("run30_val",   32'(run),   32'(fnd2(3)));
        checkOutput("run30_state", 32'(state), 32'd1);
        applyStimulus(B_START);
        checkOutput("pause_state", 32'(state), 32'd2);
        checkOutput("pause_val",   32'(run),   32'(fnd2(3)));
        waitCycles(20);
        checkOutput("pause_hold",  32'(run),   32'(fnd2(3)));
        applyStimulus(B_STOP);
        checkOutput("stop_state",  32'(state), 32'd0);
        checkOutput("stop_val",    32'(run),   32'(fnd2(0)));

        // Laps taken mid-interval at values 02, 05, 07, 09, 11.
        applyStimulus(B_START);
        waitCycles(23);
        applyStimulus(B_LAP);
        checkOutput("lap1_cnt", 32'(lapCnt), 32'd1);
        checkOutput("lap1_idx", 32'(lapIdx), 32'd0);
        checkOutput("lap1_val", 32'(lap),    32'(fnd2(2)));
        waitCycles(28);
        applyStimulus(B_LAP);
        waitCycles(18);
        applyStimulus(B_LAP);
        waitCycles(18);
        applyStimulus(B_LAP);
        waitCycles(18);
        applyStimulus(B_LAP);
        checkOutput("lap5_cnt", 32'(lapCnt), 32'd4);
        checkOutput("lap5_idx", 32'(lapIdx), 32'd3);
        checkOutput("lap5_val", 32'(lap),    32'(fnd2(11)));
        applyStimulus(B_VIEW);
        checkOutput("view1_idx", 32'(lapIdx), 32'd0);
        checkOutput("view1_val", 32'(lap),    32'(fnd2(5)));
        checkOutput("run118",    32'(run),    32'(fnd2(11)));
        applyStimulus(B_VIEW);
        checkOutput("view2_idx", 32'(lapIdx), 32'd1);
        checkOutput("view2_val", 32'(lap),    32'(fnd2(7)));

        // Lap and View together: only the lap (value 12) is taken.
        applyStimulus(B_LAP | B_VIEW);
        checkOutput("lapview_cnt", 32'(lapCnt), 32'd4);
        checkOutput("lapview_idx", 32'(lapIdx), 32'd3);
        checkOutput("lapview_val", 32'(lap),    32'(fnd2(12)));
        applyStimulus(B_VIEW);
        checkOutput("wrap_idx", 32'(lapIdx), 32'd0);
        checkOutput("wrap_val", 32'(lap),    32'(fnd2(7)));

        // Lap while paused is ignored.
        applyStimulus(B_START);
        checkOutput("p2_state", 32'(state), 32'd2);
        checkOutput("p2_val",   32'(run),   32'(fnd2(12)));
        applyStimulus(B_LAP);
        checkOutput("plap_cnt", 32'(lapCnt), 32'd4);
        checkOutput("plap_idx", 32'(lapIdx), 32'd0);
        checkOutput("plap_val", 32'(lap),    32'(fnd2(7)));

        // Start and Stop together while running: Stop wins, laps kept.
        applyStimulus(B_START);
        checkOutput("resume_state", 32'(state), 32'd1);
        applyStimulus(B_START | B_STOP);
        checkOutput("ss_state", 32'(state),  32'd0);
        checkOutput("ss_val",   32'(run),    32'(fnd2(0)));
        checkOutput("ss_cnt",   32'(lapCnt), 32'd4);

        // Start held low for 50 clocks is a single press.
        fStart = 1'b0;
        waitCycles(50);
        checkOutput("hold_state", 32'(state), 32'd1);
        checkOutput("hold_val",   32'(run),   32'(fnd2(4)));
        fStart = 1'b1;
        waitCycles(1);
        applyStimulus(B_STOP);
        checkOutput("hold_stop", 32'(state), 32'd0);

        // Run to 99, then one more tick wraps to 00 and sets the flag.
        applyStimulus(B_START);
        waitCycles(994);
        checkOutput("at99_val", 32'(run), 32'(fnd2(99)));
        checkOutput("at99_ovf", 32'(ovf), 32'd0);
        waitCycles(10);
        checkOutput("wrap_val00", 32'(run),   32'(fnd2(0)));
        checkOutput("wrap_ovf",   32'(ovf),   32'd1);
        checkOutput("wrap_state", 32'(state), 32'd1);
        applyStimulus(B_STOP);
        checkOutput("stop1_ovf", 32'(ovf),    32'd1);
        checkOutput("stop1_cnt", 32'(lapCnt), 32'd4);
        applyStimulus(B_STOP);
        checkOutput("clr_ovf", 32'(ovf),    32'd0);
        checkOutput("clr_cnt", 32'(lapCnt), 32'd0);
        checkOutput("clr_idx", 32'(lapIdx), 32'd0);
        checkOutput("clr_lap", 32'(lap),    32'(fnd2(0)));
        applyStimulus(B_VIEW);
        checkOutput("view_empty", 32'(lapIdx), 32'd0);

        // Asynchronous reset between clock edges while running.
        applyStimulus(B_START);
        waitCycles(23);
        applyStimulus(B_LAP);
        waitCycles(10);
        checkOutput("pre_rst_val", 32'(run),    32'(fnd2(3)));
        checkOutput("pre_rst_cnt", 32'(lapCnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_run",   32'(run),    32'(fnd2(0)));
        checkOutput("arst_state", 32'(state),  32'd0);
        checkOutput("arst_cnt",   32'(lapCnt), 32'd0);
        checkOutput("arst_lap",   32'(lap),    32'(fnd2(0)));
        @(negedge clk);
        rst_n = 1'b1;
        waitCycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
